// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: default datapath width and the divider FSM encoding.
package cpu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The bit shifted out of R must take part in the compare, hence the extra bit.
    assign shifted = {r_i, q_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, d_i};

    assign r_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: WIDTH iterations, then one sign-fixup cycle.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] div_ans
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] step_r, step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        count_d     = count_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                if (start) begin
                    neg_quot_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d  = is_signed & dividend[WIDTH-1];
                    q_d        = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    d_d        = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    r_d        = '0;
                    count_d    = '0;
                    dbz_d      = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DIV_DONE;
                    end else begin
                        state_d = DIV_RUN;
                    end
                end else if (state_q == DIV_DONE) begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                r_d     = step_r;
                q_d     = step_q;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                quotient_d  = neg_quot_q ? -q_q : q_q;
                remainder_d = neg_rem_q  ? -r_q : r_q;
                state_d     = DIV_DONE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DIV_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            count_q     <= count_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy        = (state_q == DIV_RUN) || (state_q == DIV_FIX);
    assign done        = (state_q == DIV_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_ans     = {remainder_q, quotient_q};

endmodule
